gpio_apb_master: RTL
====================

# gpio_apb_master

Two-port APB requester arbiter and transfer sequencer that drives the 8-pin GPIO slave. It accepts register read/write requests from two on-chip clients, picks one per transfer, and runs the APB SETUP/ACCESS protocol (PSEL, PENABLE, PADDR, PWDATA, PWRITE). It returns PRDATA to the winning client. The block sits between the CPU-side/DMA-side clients and the GPIO peripheral and is the only APB master on that bus.

## Interface
- ADDR_W, 3, APB address width (GPIO register index 0..7)
- DATA_W, 8, APB data width
- PCLK  in  1  clock; all state changes on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- req_valid  in  2  per-client request pending; bit n = client n
- req_write  in  2  per-client direction, 1 = write
- req_addr  in  2*ADDR_W  client n address in bits [n*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  client n write data in bits [n*DATA_W +: DATA_W]
- req_grant  out  2  one-cycle pulse: client n's request latched
- rsp_valid  out  2  one-cycle pulse: client n's transfer completed
- rsp_rdata  out  DATA_W  read data of last completed read
- busy  out  1  high whenever state is not IDLE
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data from slave
- PREADY  in  1  APB ready from slave; extends ACCESS while low

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: PSEL=0, PENABLE=0. If any req_valid bit is set, arbitrate, latch the winner's write/addr/wdata into PWRITE/PADDR/PWDATA, and pulse req_grant[winner]. Then go to SETUP. Otherwise stay in IDLE.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. If PREADY=0, hold with all APB outputs stable. If PREADY=1, the transfer completes: on a read, register PRDATA into rsp_rdata; pulse rsp_valid[winner]; go to IDLE.
- PADDR, PWRITE and PWDATA hold their latched values until the next grant, including through IDLE.
- A client holds req_valid and its fields stable until it sees req_grant. It may deassert or present a new request after the grant; a new request is not considered until the FSM is back in IDLE.
- Arbitration uses fixed priority, client 0 over client 1, unless the round-robin option is compiled in (see Configuration).
- rsp_rdata is unchanged by write completions and holds the last read value.
- Unused req_valid bits and fields of the losing client are ignored; the losing request stays pending.

## Timing
- Reset (PRESETn low, asynchronous) forces the following immediately, independent of PCLK: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, req_grant=0, rsp_valid=0, rsp_rdata=0, busy=0, RR pointer=1.
- Reset during SETUP/ACCESS aborts the transfer. No rsp_valid is produced for it.
- Cycle numbering, with req_valid sampled high in IDLE at edge 0:
  - Edge 0: req_grant pulses and state becomes SETUP (PSEL=1).
  - Edge 1: ACCESS (PENABLE=1).
  - First edge with PREADY=1 in ACCESS: rsp_valid pulses for that cycle and state returns to IDLE.
- Minimum transfer is 3 cycles: request to rsp_valid with PREADY tied high, i.e. SETUP, ACCESS, then rsp_valid with busy=0.
- Back-to-back: the next grant occurs on the edge after returning to IDLE. Minimum spacing between grants is 3 cycles.
- req_grant and rsp_valid are never high for both bits at once.
- PREADY is ignored outside ACCESS.

## Configuration
- GPIO_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-winner pointer is updated on each grant.
  - When both clients request in the same IDLE cycle, the client that did not win last is granted.
  - Pointer reset value is 1, so client 0 wins the first contention.
- GPIO_ARB_RR_EN undefined: fixed priority, client 0 always wins contention. The pointer logic is absent.

## Test plan
- Client 0 writes addr 0 data 0xFF, PREADY tied 1 -> req_grant=01 at edge 0; PSEL=1/PENABLE=0 next, then PSEL=1/PENABLE=1 with PADDR=0, PWDATA=0xFF, PWRITE=1; rsp_valid=01 at cycle 3; rsp_rdata unchanged.
- Client 1 reads addr 4, slave PRDATA=0xA5, PREADY low for 2 ACCESS cycles -> ACCESS lasts 3 cycles with APB outputs stable; rsp_valid=10 and rsp_rdata=0xA5 after PREADY rises.
- Both clients request continuously, fixed priority (no macro) -> every grant goes to client 0; client 1 is never granted while client 0 stays valid.
- Both clients request continuously with GPIO_ARB_RR_EN -> grants alternate 01, 10, 01, 10, each spaced 3 cycles with PREADY=1.
- PRESETn pulsed low mid-ACCESS -> PSEL and PENABLE drop to 0 without waiting for a clock edge; no rsp_valid; the next request after reset starts a fresh SETUP and client 0 wins contention.

Source files
------------

// File: rtl/gpio_apb_master.sv
// gpio_apb_master
//   Two-client APB requester for the 8-pin GPIO slave. Arbitrates between
//   two request ports, runs one APB SETUP/ACCESS transfer at a time and
//   returns the completion (and read data) to the client that won.
//
//   Optional build macro: GPIO_ARB_RR_EN
//     defined   -> round-robin arbitration using a 1-bit last-winner pointer
//     undefined -> fixed priority, client 0 wins contention
//
// Ports
//   PCLK, PRESETn                 clock, async active-low reset
//   req_valid/write/addr/wdata    per-client request (client n in slice n)
//   req_grant                     1-cycle pulse, client n's request latched
//   rsp_valid                     1-cycle pulse, client n's transfer done
//   rsp_rdata                     data of the last completed read
//   busy                          FSM not in IDLE
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY  APB requester side
module gpio_apb_master #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_grant,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                busy,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q, state_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          rsp_q, rsp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                owner_q, owner_d;   // client that owns the current transfer
  logic                win;                // arbitration result this cycle
`ifdef GPIO_ARB_RR_EN
  logic                last_q, last_d;     // last granted client
`endif

  // Arbitration: a lone requester always wins; contention is resolved by
  // fixed priority or by handing the bus to the client that did not win last.
  always_comb begin
    win = req_valid[0] ? 1'b0 : 1'b1;
`ifdef GPIO_ARB_RR_EN
    if (req_valid == 2'b11) win = ~last_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    grant_d  = 2'b00;
    rsp_d    = 2'b00;
    rdata_d  = rdata_q;
    owner_d  = owner_q;
`ifdef GPIO_ARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          pwrite_d = win ? req_write[1] : req_write[0];
          paddr_d  = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          pwdata_d = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          grant_d  = win ? 2'b10 : 2'b01;
          owner_d  = win;
`ifdef GPIO_ARB_RR_EN
          last_d   = win;
`endif
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          if (!pwrite_q) rdata_d = PRDATA;
          rsp_d   = owner_q ? 2'b10 : 2'b01;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      grant_q  <= 2'b00;
      rsp_q    <= 2'b00;
      rdata_q  <= '0;
      owner_q  <= 1'b0;
`ifdef GPIO_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      grant_q  <= grant_d;
      rsp_q    <= rsp_d;
      rdata_q  <= rdata_d;
      owner_q  <= owner_d;
`ifdef GPIO_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign busy      = (state_q != IDLE);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign req_grant = grant_q;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;

endmodule
